mem_port_arbiter: RTL and testbench

Shares the core's single data-RAM port between the instruction fetch unit (IFU, word reads only) and the load/store unit (LSU, byte-selected reads and writes). Grants are issued combinationally in the request cycle. The block records which requester owns each in-flight read so the one-cycle-latency RAM response goes back to the correct unit. LSU has priority, and a starvation counter guarantees IFU forward progress.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single data-RAM port between instruction fetch
// (word reads) and load/store (byte-selected reads and writes). Grants are
// combinational in the request cycle. Each read's owner is recorded so that
// the one-cycle-latency RAM response is steered back to the unit that asked.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        ifu_req_i,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_gnt_o,
  output logic        ifu_rvalid_o,
  output logic [31:0] ifu_rdata_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [3:0]  lsu_sel_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_stall_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  localparam logic [3:0] LIMIT_C    = 4'(STARVE_LIMIT);
  localparam logic [1:0] OWN_NONE_C = 2'b00;
  localparam logic [1:0] OWN_IFU_C  = 2'b01;
  localparam logic [1:0] OWN_LSU_C  = 2'b10;

  logic       ifu_gnt_s;
  logic       lsu_gnt_s;
  logic       ifu_rvalid_s;
  logic       lsu_rvalid_s;
  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;
  logic [1:0] rd_owner_q;
  logic [1:0] rd_owner_d;
  logic       ifu_kill_q;
  logic       ifu_kill_d;

  // Arbitration: LSU wins ties unless IFU has waited STARVE_LIMIT grants.
  always_comb begin
    ifu_gnt_s = 1'b0;
    lsu_gnt_s = 1'b0;
    if (rst_i) begin
      ifu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end else if (ifu_req_i && lsu_req_i) begin
      if (starve_cnt_q >= LIMIT_C) begin
        ifu_gnt_s = 1'b1;
      end else begin
        lsu_gnt_s = 1'b1;
      end
    end else if (ifu_req_i) begin
      ifu_gnt_s = 1'b1;
    end else if (lsu_req_i) begin
      lsu_gnt_s = 1'b1;
    end else begin
      ifu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end
  end

  // RAM port mux: the granted requester drives the RAM, idle port drives zeros.
  always_comb begin
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = 32'h0000_0000;
    ram_sel_o   = 4'b0000;
    ram_wdata_o = 32'h0000_0000;
    if (ifu_gnt_s) begin
      ram_ce_o   = 1'b1;
      ram_sel_o  = 4'b1111;
      ram_addr_o = ifu_addr_i;
    end else if (lsu_gnt_s) begin
      ram_ce_o    = 1'b1;
      ram_we_o    = lsu_we_i;
      ram_sel_o   = lsu_sel_i;
      ram_addr_o  = lsu_addr_i;
      ram_wdata_o = lsu_wdata_i;
    end else begin
      ram_ce_o = 1'b0;
    end
  end

  // Next-state: starvation count, owner of the read in flight, flush kill.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    rd_owner_d   = OWN_NONE_C;
    ifu_kill_d   = flush_i & ifu_gnt_s;
    if (ifu_gnt_s || !ifu_req_i) begin
      starve_cnt_d = 4'd0;
    end else if (lsu_gnt_s && (starve_cnt_q < LIMIT_C)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
    if (ifu_gnt_s) begin
      rd_owner_d = OWN_IFU_C;
    end else if (lsu_gnt_s && !lsu_we_i) begin
      rd_owner_d = OWN_LSU_C;
    end else begin
      rd_owner_d = OWN_NONE_C;
    end
  end

  // State registers with synchronous reset; reset drops any read in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= 4'd0;
      rd_owner_q   <= OWN_NONE_C;
      ifu_kill_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
      ifu_kill_q   <= ifu_kill_d;
    end
  end

  // Response steering: flush in either the grant or response cycle kills IFU data.
  always_comb begin
    ifu_rvalid_s = 1'b0;
    lsu_rvalid_s = 1'b0;
    if (rst_i) begin
      ifu_rvalid_s = 1'b0;
      lsu_rvalid_s = 1'b0;
    end else begin
      ifu_rvalid_s = (rd_owner_q == OWN_IFU_C) && !ifu_kill_q && !flush_i;
      lsu_rvalid_s = (rd_owner_q == OWN_LSU_C);
    end
  end

  assign ifu_gnt_o    = ifu_gnt_s;
  assign lsu_gnt_o    = lsu_gnt_s;
  assign lsu_stall_o  = lsu_req_i & ~lsu_gnt_s & ~rst_i;
  assign ifu_rvalid_o = ifu_rvalid_s;
  assign lsu_rvalid_o = lsu_rvalid_s;
  assign ifu_rdata_o  = ifu_rvalid_s ? ram_rdata_i : 32'h0000_0000;
  assign lsu_rdata_o  = lsu_rvalid_s ? ram_rdata_i : 32'h0000_0000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, two hand-written
// multi-cycle sequences (starvation, reset mid-operation) and a randomized
// run checked against a request/response-level reference model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;
  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;
  localparam logic [31:0] Z32 = 32'h0000_0000;
  localparam logic [3:0]  Z4  = 4'h0;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        ifu_req_i = 1'b0;
  logic [31:0] ifu_addr_i = 32'h0;
  logic        ifu_gnt_o, ifu_rvalid_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [31:0] lsu_addr_i = 32'h0;
  logic [3:0]  lsu_sel_i = 4'h0;
  logic [31:0] lsu_wdata_i = 32'h0;
  logic        lsu_gnt_o, lsu_rvalid_o, lsu_stall_o;
  logic [31:0] lsu_rdata_o;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_rdata_i = 32'h0;

  int total = 0;
  int bad = 0;
  int step_no = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_sel_i(lsu_sel_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_stall_o(lsu_stall_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_sel_o(ram_sel_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  typedef struct {
    logic        rst, flush, ireq;
    logic [31:0] iaddr;
    logic        lreq, lwe;
    logic [31:0] laddr;
    logic [3:0]  lsel;
    logic [31:0] lwdata, rdata;
    logic        ig, lg, irv, lrv;
    logic [31:0] ird, lrd;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic flush, input logic ireq,
                              input logic [31:0] iaddr, input logic lreq, input logic lwe,
                              input logic [31:0] laddr, input logic [3:0] lsel,
                              input logic [31:0] lwdata, input logic [31:0] rdata,
                              input logic ig, input logic lg, input logic irv, input logic lrv,
                              input logic [31:0] ird, input logic [31:0] lrd);
    vec_t v;
    v.rst = rst; v.flush = flush; v.ireq = ireq; v.iaddr = iaddr;
    v.lreq = lreq; v.lwe = lwe; v.laddr = laddr; v.lsel = lsel;
    v.lwdata = lwdata; v.rdata = rdata;
    v.ig = ig; v.lg = lg; v.irv = irv; v.lrv = lrv; v.ird = ird; v.lrd = lrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then check every output against the vector.
  // RAM-side and stall expectations follow from the expected grant.
  task automatic apply(input vec_t v);
    logic        ece, ewe, estall;
    logic [31:0] eaddr, ewd;
    logic [3:0]  esel;
    @(negedge clk_i);
    rst_i = v.rst; flush_i = v.flush;
    ifu_req_i = v.ireq; ifu_addr_i = v.iaddr;
    lsu_req_i = v.lreq; lsu_we_i = v.lwe; lsu_addr_i = v.laddr;
    lsu_sel_i = v.lsel; lsu_wdata_i = v.lwdata; ram_rdata_i = v.rdata;
    #1;
    ece = 1'b0; ewe = 1'b0; eaddr = Z32; esel = Z4; ewd = Z32;
    if (v.ig) begin
      ece = 1'b1; esel = 4'b1111; eaddr = v.iaddr;
    end else if (v.lg) begin
      ece = 1'b1; ewe = v.lwe; esel = v.lsel; eaddr = v.laddr; ewd = v.lwdata;
    end
    estall = !v.rst && v.lreq && !v.lg;
    chk("ifu_gnt",    32'(ifu_gnt_o),    32'(v.ig));
    chk("lsu_gnt",    32'(lsu_gnt_o),    32'(v.lg));
    chk("ifu_rvalid", 32'(ifu_rvalid_o), 32'(v.irv));
    chk("lsu_rvalid", 32'(lsu_rvalid_o), 32'(v.lrv));
    chk("ifu_rdata",  ifu_rdata_o,       v.ird);
    chk("lsu_rdata",  lsu_rdata_o,       v.lrd);
    chk("lsu_stall",  32'(lsu_stall_o),  32'(estall));
    chk("ram_ce",     32'(ram_ce_o),     32'(ece));
    chk("ram_we",     32'(ram_we_o),     32'(ewe));
    chk("ram_addr",   ram_addr_o,        eaddr);
    chk("ram_sel",    32'(ram_sel_o),    32'(esel));
    chk("ram_wdata",  ram_wdata_o,       ewd);
    step_no++;
  endtask

  vec_t tbl [19];
  vec_t v;
  int   streak, pend;
  bit   pend_kill, iw, lw;
  logic        h_ireq, h_lreq, h_lwe;
  logic [31:0] h_iaddr, h_laddr, h_lwd;
  logic [3:0]  h_lsel;

  initial begin
    // rst,flush,ireq,iaddr, lreq,lwe,laddr,lsel,lwdata, rdata, ig,lg,irv,lrv, ird,lrd
    tbl[0]  = mk(L1,L0,L1,32'h100, L1,L0,32'h200,4'h3,Z32, Z32,          L0,L0,L0,L0, Z32,Z32);
    tbl[1]  = mk(L0,L0,L1,32'h100, L0,L0,Z32,Z4,Z32,       Z32,          L1,L0,L0,L0, Z32,Z32);
    tbl[2]  = mk(L0,L0,L0,Z32,     L0,L0,Z32,Z4,Z32,       32'hDEADBEEF, L0,L0,L1,L0, 32'hDEADBEEF,Z32);
    tbl[3]  = mk(L0,L0,L1,32'h104, L1,L0,32'h200,4'h3,Z32, Z32,          L0,L1,L0,L0, Z32,Z32);
    tbl[4]  = mk(L0,L0,L0,Z32,     L0,L0,Z32,Z4,Z32,       32'h12345678, L0,L0,L0,L1, Z32,32'h12345678);
    tbl[5]  = mk(L0,L0,L0,Z32,     L1,L1,32'h300,4'h4,32'h00AA0000, Z32, L0,L1,L0,L0, Z32,Z32);
    tbl[6]  = mk(L0,L0,L0,Z32,     L0,L0,Z32,Z4,Z32,       32'h55555555, L0,L0,L0,L0, Z32,Z32);
    tbl[7]  = mk(L0,L1,L1,32'h400, L0,L0,Z32,Z4,Z32,       Z32,          L1,L0,L0,L0, Z32,Z32);
    tbl[8]  = mk(L0,L0,L0,Z32,     L0,L0,Z32,Z4,Z32,       32'hAAAA0000, L0,L0,L0,L0, Z32,Z32);
    tbl[9]  = mk(L0,L0,L1,32'h404, L0,L0,Z32,Z4,Z32,       Z32,          L1,L0,L0,L0, Z32,Z32);
    tbl[10] = mk(L0,L1,L0,Z32,     L0,L0,Z32,Z4,Z32,       32'h11112222, L0,L0,L0,L0, Z32,Z32);
    tbl[11] = mk(L0,L0,L1,32'h408, L0,L0,Z32,Z4,Z32,       Z32,          L1,L0,L0,L0, Z32,Z32);
    tbl[12] = mk(L0,L0,L0,Z32,     L1,L0,32'h20C,4'hF,Z32, 32'hCAFEF00D, L0,L1,L1,L0, 32'hCAFEF00D,Z32);
    tbl[13] = mk(L0,L1,L0,Z32,     L0,L0,Z32,Z4,Z32,       32'h0BADC0DE, L0,L0,L0,L1, Z32,32'h0BADC0DE);
    tbl[14] = mk(L0,L1,L0,Z32,     L1,L0,32'h210,4'h1,Z32, Z32,          L0,L1,L0,L0, Z32,Z32);
    tbl[15] = mk(L0,L1,L0,Z32,     L0,L0,Z32,Z4,Z32,       32'h13572468, L0,L0,L0,L1, Z32,32'h13572468);
    tbl[16] = mk(L0,L0,L0,Z32,     L1,L0,32'h214,4'h8,Z32, Z32,          L0,L1,L0,L0, Z32,Z32);
    tbl[17] = mk(L1,L0,L1,32'h500, L1,L0,32'h214,4'h8,Z32, 32'hFFFFFFFF, L0,L0,L0,L0, Z32,Z32);
    tbl[18] = mk(L0,L0,L0,Z32,     L0,L0,Z32,Z4,Z32,       32'hFFFFFFFF, L0,L0,L0,L0, Z32,Z32);

    for (int k = 0; k < 19; k++) apply(tbl[k]);

    // Starvation: both requesting; LSU turns into a store once IFU is at the limit.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] rd;
      logic ig_e, lrv_e, irv_e;
      rd    = 32'hA000_0000 + 32'(i);
      ig_e  = (i == 4) || (i == 9);
      lrv_e = (i >= 1) && (i <= 4);
      irv_e = (i == 5);
      apply(mk(L0, L0, L1, 32'h600, L1, (i >= 4), 32'h700, 4'hF, 32'h0000_1234, rd,
               ig_e, !ig_e, irv_e, lrv_e, irv_e ? rd : Z32, lrv_e ? rd : Z32));
    end

    // Reset with a load in flight and a partly built starvation count.
    for (int j = 0; j < 9; j++) begin
      logic [31:0] rd;
      logic rst_e, ig_e, lg_e, irv_e, lrv_e;
      rd    = 32'hB000_0000 + 32'(j);
      rst_e = (j == 3);
      ig_e  = (j == 8);
      lg_e  = !(j == 3 || j == 8);
      irv_e = (j == 0);
      lrv_e = (j == 2) || (j >= 5);
      apply(mk(rst_e, L0, L1, 32'h600, L1, (j == 0), 32'h700, 4'hF, 32'h0000_1234, rd,
               ig_e, lg_e, irv_e, lrv_e, irv_e ? rd : Z32, lrv_e ? rd : Z32));
    end

    // Randomized traffic against the reference model.
    streak = 0; pend = 0; pend_kill = 1'b0;
    h_ireq = 1'b1; h_iaddr = $urandom();
    h_lreq = 1'b1; h_lwe = 1'b0; h_laddr = $urandom(); h_lsel = 4'hF; h_lwd = $urandom();
    for (int n = 0; n < 400; n++) begin
      v.rst    = (n == 0) || ($urandom_range(31, 0) == 0);
      v.flush  = ($urandom_range(3, 0) == 0);
      v.ireq   = h_ireq;  v.iaddr = h_iaddr;
      v.lreq   = h_lreq;  v.lwe = h_lwe; v.laddr = h_laddr;
      v.lsel   = h_lsel;  v.lwdata = h_lwd;
      v.rdata  = $urandom();
      iw = 1'b0; lw = 1'b0;
      if (!v.rst) begin
        if (v.ireq && v.lreq) begin
          if (streak >= LIMIT) iw = 1'b1; else lw = 1'b1;
        end else if (v.ireq) begin
          iw = 1'b1;
        end else if (v.lreq) begin
          lw = 1'b1;
        end
      end
      v.ig  = iw;
      v.lg  = lw;
      v.irv = !v.rst && (pend == 1) && !pend_kill && !v.flush;
      v.lrv = !v.rst && (pend == 2);
      v.ird = v.irv ? v.rdata : Z32;
      v.lrd = v.lrv ? v.rdata : Z32;
      apply(v);
      if (v.rst) begin
        streak = 0; pend = 0; pend_kill = 1'b0;
      end else begin
        pend      = iw ? 1 : ((lw && !v.lwe) ? 2 : 0);
        pend_kill = iw && v.flush;
        if (lw && v.ireq) streak = (streak + 1 > LIMIT) ? LIMIT : streak + 1;
        else streak = 0;
      end
      if (iw || !h_ireq) begin
        h_ireq  = ($urandom_range(3, 0) != 0);
        h_iaddr = $urandom();
      end
      if (lw || !h_lreq) begin
        h_lreq  = ($urandom_range(3, 0) != 0);
        h_lwe   = $urandom_range(1, 0) == 1;
        h_laddr = $urandom();
        h_lsel  = 4'($urandom_range(15, 0));
        h_lwd   = $urandom();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
